store_buffer: RTL
=================

// Module: store_buffer
// PURPOSE
//   Write buffer between the single-cycle core's data port and a slower handshaked data memory.
//   Absorbs core stores in one cycle and drains them in order to memory over a req/ack interface.
//   Loads see the youngest buffered store to the same word (store-to-load forwarding).
//   Raises a stall when the queue cannot accept another store.
// PARAMETERS
//   DEPTH   4    queue entries; power of two, >= 2
//   AW      32   byte address width
//   DW      32   data width (one word per entry)
// PORTS
//   clk             in   1    rising-edge clock
//   reset           in   1    synchronous, active-high
//   WE              in   1    core store strobe
//   address_to_mem  in   AW   core load/store byte address
//   data_to_mem     in   DW   core store data
//   data_from_mem   out  DW   load data to core (combinational)
//   stall           out  1    queue cannot accept a store this cycle
//   overflow        out  1    sticky: store dropped while stalled
//   mem_req         out  1    drain request to memory
//   mem_addr        out  AW   head entry address
//   mem_wdata       out  DW   head entry data
//   mem_ack         in   1    memory accepted head write this edge
//   mem_raddr       out  AW   = address_to_mem (memory combinational read port)
//   mem_rdata       in   DW   memory read data
//   empty           out  1    no pending stores
// BEHAVIOUR
//   Reset: head/tail pointers 0, count 0, all entries invalid, mem_req 0, overflow 0, empty 1, FSM IDLE.
//     Reset mid-drain discards all pending entries; no further mem_req until a new store.
//   Matching: word compare on address[AW-1:2]; byte offsets ignored.
//   Enqueue: WE && !stall -> entry at tail gets {addr,data}, tail++ (mod DEPTH), count++ on that edge.
//   stall = (count == DEPTH) && !(mem_req && mem_ack); a same-edge dequeue frees the slot.
//   WE while stall -> store dropped, overflow set (sticky until reset).
//   Dequeue: mem_req && mem_ack -> head++ (mod DEPTH), count-- on that edge.
//     Enqueue and dequeue on the same edge -> count unchanged.
//   FSM IDLE: mem_req 0; -> DRAIN on the edge where count becomes nonzero.
//   FSM DRAIN: mem_req 1; mem_addr/mem_wdata = head entry, held stable until ack.
//     On ack -> stay in DRAIN if entries remain, else -> IDLE.
//     Minimum enqueue-to-mem_req latency: 1 cycle.
//   Forwarding: data_from_mem = data of youngest valid entry matching address_to_mem, else mem_rdata.
//     Ties resolved by age (closest to tail wins).
//     An entry popped this edge still forwards during this cycle.
//   Pointers wrap modulo DEPTH; count ranges 0..DEPTH; empty = (count == 0).
// CONFIGURATION
//   STORE_BUF_COALESCE_EN defined:
//     A store matching a valid non-head entry overwrites that entry's data.
//     No allocation; tail/count unchanged; accepted even when stall is high (no overflow).
//     The head entry is never overwritten while mem_req is high, so it always allocates.
//   Not defined: every accepted store allocates a new entry; no merging.
// TESTING
//   1 Reset then idle: reset 1 for 2 cycles -> mem_req 0, empty 1, stall 0, overflow 0.
//   2 Single store: WE, addr 0x100, data 0xDEADBEEF; ack 3 cycles later ->
//       mem_req high the next cycle with addr 0x100 / data 0xDEADBEEF held stable; empty after ack.
//   3 Fill, no ack: 4 stores to 0x0,0x4,0x8,0xC -> stall 1.
//       5th store to 0x10 -> overflow 1, count stays 4.
//       ack + WE on the same edge -> enqueue accepted, stall stays 1.
//   4 Forwarding: store 0x11 then 0x22 to 0x20 with ack held 0; load 0x20 (mem_rdata 0x99) -> 0x22.
//       Load 0x24 -> 0x99.
//   5 Coalesce (macro defined): stores 0x40=1, 0x44=2, 0x44=3 with head pending -> count 2.
//       Drained writes are 0x40=1 then 0x44=3. Without the macro: count 3, three writes in order.
//   6 Reset mid-drain: 3 entries queued, mem_req high; reset 1 cycle ->
//       next cycle mem_req 0, empty 1; later ack ignored.

Source files
------------

// File: rtl/store_buffer.sv
// store_buffer: in-order write buffer between a single-cycle core data port
// and a slower req/ack data memory. Stores are absorbed in one cycle, drained
// head-first, and loads forward from the youngest buffered store to the same
// word (byte offset ignored).
//
// Optional feature: define STORE_BUF_COALESCE_EN to merge a store into a
// matching valid non-head entry instead of allocating a new one. Merged
// stores are accepted even while stall is high.
//
// Handshake: a head write is transferred on a rising edge where
// mem_req && mem_ack are both high; mem_addr/mem_wdata stay stable while
// mem_req is high and mem_ack is low.
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          WE,
  input  logic [AW-1:0] address_to_mem,
  input  logic [DW-1:0] data_to_mem,
  output logic [DW-1:0] data_from_mem,
  output logic          stall,
  output logic          overflow,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ack,
  output logic [AW-1:0] mem_raddr,
  input  logic [DW-1:0] mem_rdata,
  output logic          empty,
  output logic          o_dbg_state
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_DRAIN = 1'b1;

  logic [0:0]    r_state;
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;
  logic          r_overflow;
  logic [DEPTH-1:0] r_valid;
  logic [AW-1:0] r_addr [DEPTH];
  logic [DW-1:0] r_data [DEPTH];

  logic [PW-1:0] w_idx [DEPTH];
  logic          w_full;
  logic          w_deq;
  logic          w_enq;
  logic          w_drop;
  logic          w_coal;
  logic          w_coal_hit;
  logic [PW-1:0] w_coal_idx;
  logic [CW-1:0] w_count_next;
  logic [0:0]    w_state_next;
  logic [DW-1:0] w_fwd_data;

  // Slot index of the i-th oldest entry (i = 0 is the head).
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_idx[i] = r_head + PW'(i);
    end
  end

  assign w_full = (r_count == CW'(DEPTH));
  assign w_deq  = mem_req && mem_ack;
  // A dequeue on the same edge frees the slot a full queue needs.
  assign stall  = w_full && !w_deq;

`ifdef STORE_BUF_COALESCE_EN
  // Youngest valid non-head entry to the same word; the head is excluded
  // because it may be on the memory bus.
  always_comb begin
    w_coal_hit = 1'b0;
    w_coal_idx = '0;
    for (int i = 1; i < DEPTH; i++) begin
      if (r_valid[w_idx[i]] &&
          (r_addr[w_idx[i]][AW-1:2] == address_to_mem[AW-1:2])) begin
        w_coal_hit = 1'b1;
        w_coal_idx = w_idx[i];
      end
    end
  end
`else
  assign w_coal_hit = 1'b0;
  assign w_coal_idx = '0;
`endif

  assign w_coal = WE && w_coal_hit;
  assign w_enq  = WE && !stall && !w_coal_hit;
  assign w_drop = WE && stall && !w_coal_hit;

  // Occupancy after this edge; simultaneous enqueue and dequeue cancel.
  always_comb begin
    w_count_next = r_count;
    if (w_enq && !w_deq) begin
      w_count_next = r_count + CW'(1);
    end else if (!w_enq && w_deq) begin
      w_count_next = r_count - CW'(1);
    end
  end

  // Drain FSM: request memory whenever entries are pending.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_count_next != '0) w_state_next = S_DRAIN;
      S_DRAIN: if (w_deq && (w_count_next == '0)) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Forward from the youngest matching entry; older matches are overridden
  // as the scan moves toward the tail.
  always_comb begin
    w_fwd_data = mem_rdata;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_valid[w_idx[i]] &&
          (r_addr[w_idx[i]][AW-1:2] == address_to_mem[AW-1:2])) begin
        w_fwd_data = r_data[w_idx[i]];
      end
    end
  end

  // Control state: pointers, occupancy, FSM, sticky overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_count <= w_count_next;
      if (w_enq)  r_tail     <= r_tail + PW'(1);
      if (w_deq)  r_head     <= r_head + PW'(1);
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  // Entry valid bits: clear the popped head, set the newly allocated tail.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= '0;
    end else begin
      if (w_deq) r_valid[r_head] <= 1'b0;
      if (w_enq) r_valid[r_tail] <= 1'b1;
    end
  end

  // Entry payload: allocate at the tail or merge into a matching entry.
  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_addr[r_tail] <= address_to_mem;
      r_data[r_tail] <= data_to_mem;
    end else if (w_coal) begin
      r_data[w_coal_idx] <= data_to_mem;
    end
  end

  assign mem_req       = (r_state == S_DRAIN);
  assign mem_addr      = r_addr[r_head];
  assign mem_wdata     = r_data[r_head];
  assign mem_raddr     = address_to_mem;
  assign data_from_mem = w_fwd_data;
  assign overflow      = r_overflow;
  assign empty         = (r_count == '0);
  assign o_dbg_state   = r_state;

endmodule
